// File: rtl/i2s_pkg.sv
// Shared I2S framing constants, the stereo sample layout and slot-position helpers.
package i2s_pkg;

  localparam int SAMPLE_BITS = 24;
  localparam int SLOT_BITS   = 32;
  localparam int FRAME_BITS  = 64;

  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_IDX_W = $clog2(SLOT_BITS);

  // Rise event of the right slot's last data bit (LSB): the frame is fully received here.
  localparam logic [BIT_CNT_W-1:0] RX_DONE_BIT = BIT_CNT_W'(SLOT_BITS + SAMPLE_BITS);

  // Left occupies the MSBs, matching the 48-bit stream layout.
  typedef struct packed {
    logic [SAMPLE_BITS-1:0] left;
    logic [SAMPLE_BITS-1:0] right;
  } stereo_sample_t;

  // Slot positions 1..SAMPLE_BITS carry data; position 0 and the tail carry 0.
  function automatic logic in_slot(input logic [SLOT_IDX_W-1:0] p);
    return (p != '0) && (p <= SLOT_IDX_W'(SAMPLE_BITS));
  endfunction

  // Sample bit carried at slot position p (MSB first, one bclk after the lrclk edge).
  function automatic logic [SLOT_IDX_W-1:0] bit_idx(input logic [SLOT_IDX_W-1:0] p);
    return SLOT_IDX_W'(SAMPLE_BITS) - p;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock divider: produces bclk, lrclk, the frame bit counter and the
// single-cycle fall/rise event strobes that the datapath acts on.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enabled_i,
  output logic                 fall_o,
  output logic                 rise_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_next_o,
  output logic                 bclk_o,
  output logic                 lrclk_o
);

  localparam int unsigned CW = $clog2(BCLK_HALF);
  localparam logic [CW-1:0] CNT_MAX = CW'(BCLK_HALF - 1);

  logic [CW-1:0]        count_q;
  logic                 bclk_q;
  logic                 lrclk_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 wrap;

  // A divider wrap toggles bclk; which way it goes decides fall vs rise.
  assign wrap           = enabled_i && (count_q == CNT_MAX);
  assign fall_o         = wrap & bclk_q;
  assign rise_o         = wrap & ~bclk_q;
  assign bit_cnt_next_o = bit_cnt_q + BIT_CNT_W'(1);
  assign bit_cnt_o      = bit_cnt_q;
  assign bclk_o         = bclk_q;
  assign lrclk_o        = lrclk_q;

  // Divider, bclk toggle and bit counter; idle (bclk low, counter at 63) when stopped.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset || !enabled_i) begin
      count_q   <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      bit_cnt_q <= '1;
    end else begin
      if (wrap) begin
        count_q <= '0;
        bclk_q  <= ~bclk_q;
      end else begin
        count_q <= count_q + CW'(1);
      end
      if (fall_o) begin
        bit_cnt_q <= bit_cnt_next_o;
        lrclk_q   <= bit_cnt_next_o[BIT_CNT_W-1];
      end
    end
  end

endmodule

// File: rtl/i2s_master.sv
// I2S bus master: owns bclk/lrclk, serializes stereo playback words onto
// sdata_o and deserializes the peer's sdata_i into stereo receive words.
module i2s_master
  import i2s_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enabled,
  input  logic [47:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun,
  output logic [47:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_overrun,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata_o,
  input  logic        sdata_i
);

  logic                  fall;
  logic                  rise;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt_next;
  logic [SLOT_IDX_W-1:0] tx_p;
  logic [SLOT_IDX_W-1:0] rx_p;

  stereo_sample_t tx_q, tx_d;
  stereo_sample_t rx_shift_q, rx_shift_d;
  stereo_sample_t rx_data_q, rx_data_d;
  logic sdata_q, sdata_d;
  logic tx_ready_q, tx_ready_d;
  logic tx_underrun_q, tx_underrun_d;
  logic rx_valid_q, rx_valid_d;
  logic rx_overrun_q, rx_overrun_d;

  i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
    .clk           (clk),
    .reset         (reset),
    .enabled_i     (enabled),
    .fall_o        (fall),
    .rise_o        (rise),
    .bit_cnt_o     (bit_cnt),
    .bit_cnt_next_o(bit_cnt_next),
    .bclk_o        (bclk),
    .lrclk_o       (lrclk)
  );

  // TX drives the position it is moving to; RX samples the position it is in.
  assign tx_p = bit_cnt_next[SLOT_IDX_W-1:0];
  assign rx_p = bit_cnt[SLOT_IDX_W-1:0];

  // Next-state logic for both datapaths and their handshakes.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    tx_d          = tx_q;
    sdata_d       = sdata_q;
    tx_ready_d    = 1'b0;
    tx_underrun_d = 1'b0;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = 1'b0;

    if (fall) begin
      sdata_d = 1'b0;
      if (in_slot(tx_p)) begin
        if (bit_cnt_next[BIT_CNT_W-1]) sdata_d = tx_q.right[bit_idx(tx_p)];
        else                           sdata_d = tx_q.left[bit_idx(tx_p)];
      end
      // Frame start: position 0 drives 0, so the freshly loaded word is used from bit 1 on.
      if (bit_cnt_next == '0) begin
        if (tx_valid) begin
          tx_d       = tx_data;
          tx_ready_d = 1'b1;
        end else begin
          tx_d          = '0;
          tx_underrun_d = 1'b1;
        end
      end
    end

    if (rise && in_slot(rx_p)) begin
      if (bit_cnt[BIT_CNT_W-1]) rx_shift_d.right[bit_idx(rx_p)] = sdata_i;
      else                      rx_shift_d.left[bit_idx(rx_p)]  = sdata_i;
    end

    // Completion includes the bit sampled in this same cycle.
    if (rise && (bit_cnt == RX_DONE_BIT)) begin
      rx_data_d    = rx_shift_d;
      rx_valid_d   = 1'b1;
      rx_overrun_d = rx_valid_q & ~rx_ready;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  // Register update; disabling idles the bus but keeps the last RX word drainable.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q          <= '0;
      sdata_q       <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else if (!enabled) begin
      tx_q          <= '0;
      sdata_q       <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_shift_q    <= '0;
      rx_overrun_q  <= 1'b0;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
    end else begin
      tx_q          <= tx_d;
      sdata_q       <= sdata_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

  assign sdata_o     = sdata_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master with BCLK_HALF=4 (bclk period 8 clk, frame 512 clk).
// n counts clk edges since the last reset release / re-enable; outputs are sampled
// on the falling clk edge after edge n.
module tb_i2s_master;

  localparam int unsigned BCLK_HALF = 4;

  logic        clk = 1'b0;
  logic        reset, enabled, tx_valid, rx_ready, sdata_drv, loop_en;
  logic [47:0] tx_data, rx_data;
  logic        tx_ready, tx_underrun, rx_valid, rx_overrun;
  logic        bclk, lrclk, sdata_o, sdata_i;

  int n      = 0;
  int checks = 0;
  int errors = 0;

  assign sdata_i = loop_en ? sdata_o : sdata_drv;

  always #5 clk = ~clk;

  i2s_master #(.BCLK_HALF(BCLK_HALF)) dut (
    .clk        (clk),
    .reset      (reset),
    .enabled    (enabled),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_underrun(tx_underrun),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_overrun (rx_overrun),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata_o    (sdata_o),
    .sdata_i    (sdata_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
  endtask

  // Expected waveforms for BCLK_HALF=4: bclk toggles every 4 edges starting high at n=4;
  // the f-th fall (n=8f) moves bit_cnt to f-1 mod 64.
  function automatic logic exp_bclk(input int t);
    return ((t / 4) % 2) == 1;
  endfunction

  function automatic logic exp_lrclk(input int t);
    int f;
    f = t / 8;
    if (f == 0) return 1'b0;
    return ((f - 1) % 64) >= 32;
  endfunction

  function automatic logic exp_sdata(input int t, input logic [47:0] w);
    int f, k, p;
    f = t / 8;
    if (f == 0) return 1'b0;
    k = (f - 1) % 64;
    p = k % 32;
    if (p < 1 || p > 24) return 1'b0;
    return (k >= 32) ? w[24 - p] : w[48 - p];
  endfunction

  initial begin
    int bad_bclk, bad_lr, bad_sd, ready_cnt, ready_bad, under_cnt, lr_bad_edge;
    int bclk_rise0, bclk_rise1, lr_rise0, lr_rise1, pad_ones, k, p;
    int ovr, ovr_at, under_first, sd_ones;
    logic prev_bclk, prev_lr;
    logic [23:0] l_cap, r_cap;
    logic [47:0] w972;

    reset = 1'b1; enabled = 1'b1; tx_valid = 1'b1; rx_ready = 1'b0;
    sdata_drv = 1'b0; loop_en = 1'b0; tx_data = 48'hA5A5A5_3C3C3C;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata_o, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_underrun", tx_underrun, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_overrun", rx_overrun, 0);

    // Clock generation and TX serialization over two frames
    reset = 1'b0; n = 0;
    bad_bclk = 0; bad_lr = 0; bad_sd = 0; ready_cnt = 0; ready_bad = 0; under_cnt = 0;
    lr_bad_edge = 0; bclk_rise0 = -1; bclk_rise1 = -1; lr_rise0 = -1; lr_rise1 = -1;
    pad_ones = 0; l_cap = '0; r_cap = '0; prev_bclk = 1'b0; prev_lr = 1'b0;
    for (int i = 0; i < 1040; i++) begin
      step();
      if (bclk !== exp_bclk(n)) bad_bclk++;
      if (lrclk !== exp_lrclk(n)) bad_lr++;
      if (sdata_o !== exp_sdata(n, 48'hA5A5A5_3C3C3C)) bad_sd++;
      if (tx_ready) begin
        ready_cnt++;
        if ((n % 512) != 8) ready_bad++;
      end
      if (tx_underrun) under_cnt++;
      if (lrclk !== prev_lr && !(prev_bclk === 1'b1 && bclk === 1'b0)) lr_bad_edge++;
      if (lrclk && !prev_lr) begin
        if (lr_rise0 < 0) lr_rise0 = n;
        else if (lr_rise1 < 0) lr_rise1 = n;
      end
      if (bclk && !prev_bclk) begin
        if (bclk_rise0 < 0) bclk_rise0 = n;
        else if (bclk_rise1 < 0) bclk_rise1 = n;
        // Peer-side capture of frame 0, sampled at each bclk rise
        if (n >= 12 && n <= 516) begin
          k = (n - 12) / 8;
          p = k % 32;
          if (p >= 1 && p <= 24) begin
            if (k < 32) l_cap[24 - p] = sdata_o;
            else        r_cap[24 - p] = sdata_o;
          end else if (sdata_o) begin
            pad_ones++;
          end
        end
      end
      prev_bclk = bclk;
      prev_lr   = lrclk;
    end
    check("bclk_wave", bad_bclk, 0);
    check("bclk_first_rise", bclk_rise0, 4);
    check("bclk_period", bclk_rise1 - bclk_rise0, 8);
    check("lrclk_wave", bad_lr, 0);
    check("lrclk_first_rise", lr_rise0, 264);
    check("lrclk_period", lr_rise1 - lr_rise0, 512);
    check("lrclk_only_on_bclk_fall", lr_bad_edge, 0);
    check("sdata_wave", bad_sd, 0);
    check("tx_left_word", l_cap, 24'hA5A5A5);
    check("tx_right_word", r_cap, 24'h3C3C3C);
    check("tx_pad_bits_zero", pad_ones, 0);
    check("tx_ready_count", ready_cnt, 3);
    check("tx_ready_only_frame_start", ready_bad, 0);
    check("tx_no_underrun", under_cnt, 0);

    // Underrun: frame 0 valid, then tx_valid low for frames 1 and 2
    tx_valid = 1'b1; tx_data = 48'hA5A5A5_3C3C3C;
    do_reset();
    run_to(100);
    tx_valid = 1'b0;
    ready_cnt = 0; under_cnt = 0; under_first = -1; sd_ones = 0;
    while (n < 1540) begin
      step();
      if (tx_ready) ready_cnt++;
      if (tx_underrun) begin
        under_cnt++;
        if (under_first < 0) under_first = n;
      end
      if (n >= 513 && sdata_o) sd_ones++;
    end
    check("udr_pulse_count", under_cnt, 2);
    check("udr_first_cycle", under_first, 520);
    check("udr_no_tx_ready", ready_cnt, 0);
    check("udr_sdata_zero", sd_ones, 0);

    // Loopback
    tx_valid = 1'b1; tx_data = 48'h800001_7FFFFF; loop_en = 1'b1; rx_ready = 1'b0;
    do_reset();
    run_to(8);
    check("lb_tx_ready_frame_start", tx_ready, 1);
    run_to(9);
    check("lb_tx_ready_one_cycle", tx_ready, 0);
    run_to(459);
    check("lb_rx_valid_before", rx_valid, 0);
    step();
    check("lb_rx_valid_at_done", rx_valid, 1);
    check("lb_rx_data", rx_data, 48'h8000017FFFFF);
    check("lb_no_overrun", rx_overrun, 0);
    run_to(599);
    check("lb_rx_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("lb_rx_valid_accepted", rx_valid, 0);

    // Overrun across two unaccepted completions (972, 1484)
    run_to(700);
    tx_data = 48'h123456_ABCDEF;
    ovr = 0; ovr_at = -1; w972 = '0;
    while (n < 1490) begin
      step();
      if (rx_overrun) begin
        ovr++;
        ovr_at = n;
      end
      if (n == 972) w972 = rx_data;
    end
    check("ovr_pulse_count", ovr, 1);
    check("ovr_pulse_cycle", ovr_at, 1484);
    check("ovr_first_word", w972, 48'h8000017FFFFF);
    check("ovr_rx_data_second", rx_data, 48'h123456ABCDEF);
    check("ovr_rx_valid", rx_valid, 1);

    // rx_ready exactly at the completion cycle (1996): no overrun, new word loads
    tx_data = 48'hFFFFFF_000000;
    run_to(1995);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check("acc_no_overrun", rx_overrun, 0);
    check("acc_rx_valid", rx_valid, 1);
    check("acc_rx_data", rx_data, 48'hFFFFFF000000);
    step();
    check("acc_rx_valid_after", rx_valid, 1);

    // Reset at bit_cnt=20 (left slot bit 4 of FFFFFF is on the wire)
    run_to(2219);
    check("mid_pre_sdata", sdata_o, 1);
    reset = 1'b1;
    step();
    check("mid_rst_bclk", bclk, 0);
    check("mid_rst_lrclk", lrclk, 0);
    check("mid_rst_sdata", sdata_o, 0);
    check("mid_rst_tx_ready", tx_ready, 0);
    check("mid_rst_underrun", tx_underrun, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    check("mid_rst_rx_data", rx_data, 0);
    check("mid_rst_overrun", rx_overrun, 0);
    reset = 1'b0; n = 0;
    run_to(4);
    check("post_rst_first_rise", bclk, 1);
    run_to(8);
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_lrclk", lrclk, 0);
    check("post_rst_bit0", sdata_o, 0);
    run_to(16);
    check("post_rst_left_msb", sdata_o, 1);

    // Enable dropped mid-frame (right slot, bclk high)
    run_to(460);
    check("en_rx_valid", rx_valid, 1);
    check("en_rx_data", rx_data, 48'hFFFFFF000000);
    run_to(462);
    check("en_pre_bclk", bclk, 1);
    check("en_pre_lrclk", lrclk, 1);
    enabled = 1'b0;
    step();
    check("dis_bclk", bclk, 0);
    check("dis_lrclk", lrclk, 0);
    check("dis_sdata", sdata_o, 0);
    check("dis_rx_valid_kept", rx_valid, 1);
    check("dis_rx_data_kept", rx_data, 48'hFFFFFF000000);
    run_to(483);
    check("dis_bclk_idle", bclk, 0);
    check("dis_rx_valid_still", rx_valid, 1);
    enabled = 1'b1; n = 0;
    run_to(3);
    check("reen_bclk_low", bclk, 0);
    run_to(4);
    check("reen_first_rise", bclk, 1);
    run_to(8);
    check("reen_tx_ready", tx_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
